// File: rtl/alu_mc_if.sv
// Operand/result handshake bundle for alu_mc.
// master drives requests and accepts results; slave is the ALU.
interface alu_mc_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) ();
    logic               in_valid_i;
    logic               in_ready_o;
    logic [WIDTH-1:0]   src1_i;
    logic [WIDTH-1:0]   src2_i;
    logic [3:0]         ctrl_i;
    logic [SHAMT_W-1:0] shamt_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [WIDTH-1:0]   result_o;
    logic               zero_o;
    logic               div0_o;

    modport master (
        output in_valid_i, src1_i, src2_i, ctrl_i, shamt_i,
        output out_ready_i,
        input  in_ready_o, out_valid_o, result_o, zero_o, div0_o
    );

    modport slave (
        input  in_valid_i, src1_i, src2_i, ctrl_i, shamt_i,
        input  out_ready_i,
        output in_ready_o, out_valid_o, result_o, zero_o, div0_o
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU with iterative shift-add multiplier.
// Define ALU_MC_DIV_EN to build the restoring divider (DIVU/REMU).
module alu_mc #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input logic   clk_i,
    input logic   rst_n_i,
    alu_mc_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;

    localparam logic [SHAMT_W-1:0] LAST = SHAMT_W'(WIDTH - 1);

    state_t             state_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic [WIDTH-1:0]   mc_q;
    logic [WIDTH-1:0]   mp_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   result_q;
    logic               zero_q;
    logic               div0_q;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] acc_nxt;
    logic             is_mul;

    assign a = bus.src1_i;
    assign b = bus.src2_i;
    assign is_mul = (bus.ctrl_i == 4'd9);

    always_comb begin
        alu_res = '0;
        case (bus.ctrl_i)
            4'd0:  alu_res = a & b;
            4'd1:  alu_res = a | b;
            4'd2:  alu_res = a + b;
            4'd3:  alu_res = b >> bus.shamt_i;
            4'd4:  alu_res = b >> a[SHAMT_W-1:0];
            4'd5:  alu_res = b << (WIDTH / 2);
            4'd6:  alu_res = a - b;
            4'd7:  alu_res = ($signed(a) < $signed(b)) ?
                             WIDTH'(1) : '0;
            4'd8:  alu_res = a - b;
            4'd12: alu_res = ~(a | b);
            default: alu_res = '0;
        endcase
    end

    // mc_q holds the left-shifting multiplicand, mp_q the multiplier
    assign acc_nxt = acc_q + (mp_q[0] ? mc_q : '0);

`ifdef ALU_MC_DIV_EN
    // Divider reuses the datapath: mc_q=dividend/quotient,
    // acc_q=partial remainder, mp_q=divisor.
    logic             is_div;
    logic             rem_sel_q;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] div_res;

    assign is_div = (bus.ctrl_i == 4'd10) ||
                    (bus.ctrl_i == 4'd11);

    always_comb begin
        r_sh    = {acc_q, mc_q[WIDTH-1]};
        diff    = r_sh - {1'b0, mp_q};
        ge      = ~diff[WIDTH];
        rem_nxt = ge ? diff[WIDTH-1:0] : r_sh[WIDTH-1:0];
        quo_nxt = {mc_q[WIDTH-2:0], ge};
        div_res = rem_sel_q ? rem_nxt : quo_nxt;
    end
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mc_q      <= '0;
            mp_q      <= '0;
            acc_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            div0_q    <= 1'b0;
`ifdef ALU_MC_DIV_EN
            rem_sel_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid_i) begin
                        cnt_q  <= '0;
                        div0_q <= 1'b0;
                        unique case (1'b1)
                            is_mul: begin
                                mc_q    <= a;
                                mp_q    <= b;
                                acc_q   <= '0;
                                state_q <= MUL;
                            end
`ifdef ALU_MC_DIV_EN
                            is_div: begin
                                mc_q      <= a;
                                mp_q      <= b;
                                acc_q     <= '0;
                                rem_sel_q <= bus.ctrl_i[0];
                                state_q   <= DIV;
                            end
`endif
                            default: begin
                                result_q <= alu_res;
                                zero_q   <= (alu_res == '0);
                                state_q  <= DONE;
                            end
                        endcase
                    end
                end
                MUL: begin
                    acc_q <= acc_nxt;
                    mc_q  <= mc_q << 1;
                    mp_q  <= mp_q >> 1;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        result_q <= acc_nxt;
                        zero_q   <= (acc_nxt == '0);
                        cnt_q    <= '0;
                        state_q  <= DONE;
                    end
                end
`ifdef ALU_MC_DIV_EN
                DIV: begin
                    mc_q  <= quo_nxt;
                    acc_q <= rem_nxt;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        result_q <= div_res;
                        zero_q   <= (div_res == '0);
                        div0_q   <= (mp_q == '0);
                        cnt_q    <= '0;
                        state_q  <= DONE;
                    end
                end
`endif
                DONE: begin
                    if (bus.out_ready_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready_o  = (state_q == IDLE);
    assign bus.out_valid_o = (state_q == DONE);
    assign bus.result_o    = result_q;
    assign bus.zero_o      = zero_q;
    assign bus.div0_o      = div0_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc (WIDTH=32).
// Divider vectors are selected by ALU_MC_DIV_EN.
module tb_alu_mc;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    alu_mc_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

    alu_mc #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        bus.out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready_i = 1'b0;
        check({tag, "_vld_low"}, 64'(bus.out_valid_o), 64'd0);
        check({tag, "_rdy_high"}, 64'(bus.in_ready_o), 64'd1);
    endtask

    task automatic issue(input logic [3:0] c,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [4:0] sh);
        @(negedge clk);
        bus.in_valid_i = 1'b1;
        bus.ctrl_i     = c;
        bus.src1_i     = a;
        bus.src2_i     = b;
        bus.shamt_i    = sh;
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
        bus.src1_i     = 32'hDEAD_BEEF;
        bus.src2_i     = 32'h1357_9BDF;
        bus.ctrl_i     = 4'd15;
    endtask

    task automatic run_op(input string tag,
                          input logic [3:0] c,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input logic [4:0] sh,
                          input logic [31:0] er,
                          input int elat,
                          input logic ed0);
        int lat;
        bit busy;
        issue(c, a, b, sh);
        lat  = 1;
        busy = 1'b1;
        while (!bus.out_valid_o && lat < 200) begin
            if (bus.in_ready_o) busy = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(elat));
        if (elat > 1) check({tag, "_busy"}, 64'(busy), 64'd1);
        check({tag, "_res"}, 64'(bus.result_o), 64'(er));
        check({tag, "_zero"}, 64'(bus.zero_o), 64'(er == 32'd0));
        check({tag, "_div0"}, 64'(bus.div0_o), 64'(ed0));
        consume(tag);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.in_valid_i = 1'b0;
        bus.out_ready_i = 1'b0;
        bus.src1_i     = '0;
        bus.src2_i     = '0;
        bus.ctrl_i     = '0;
        bus.shamt_i    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_res", 64'(bus.result_o), 64'd0);
        check("rst_zero", 64'(bus.zero_o), 64'd0);
        check("rst_div0", 64'(bus.div0_o), 64'd0);
        check("rst_vld", 64'(bus.out_valid_o), 64'd0);
        check("rst_rdy", 64'(bus.in_ready_o), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("sub", 4'd6, 32'd5, 32'd5, 5'd0, 32'd0, 1, 1'b0);
        run_op("slt", 4'd7, 32'hFFFF_FFFF, 32'd1, 5'd0,
               32'd1, 1, 1'b0);
        run_op("nor", 4'd12, 32'd0, 32'd0, 5'd0,
               32'hFFFF_FFFF, 1, 1'b0);
        run_op("lui", 4'd5, 32'd0, 32'h1234, 5'd0,
               32'h1234_0000, 1, 1'b0);
        run_op("srlv", 4'd4, 32'd36, 32'h8000_0000, 5'd0,
               32'h0800_0000, 1, 1'b0);
        run_op("srl", 4'd3, 32'd0, 32'hF0, 5'd4, 32'hF, 1, 1'b0);
        run_op("and", 4'd0, 32'hF0F0_1234, 32'h0FF0_00FF,
               5'd0, 32'h00F0_0034, 1, 1'b0);
        run_op("or", 4'd1, 32'hA000_0001, 32'h0500_0010,
               5'd0, 32'hA500_0011, 1, 1'b0);
        run_op("bgez", 4'd8, 32'd3, 32'd5, 5'd0,
               32'hFFFF_FFFE, 1, 1'b0);
        run_op("op13", 4'd13, 32'd7, 32'd9, 5'd0, 32'd0, 1, 1'b0);
        run_op("mul_ff", 4'd9, 32'hFFFF_FFFF, 32'd2, 5'd0,
               32'hFFFF_FFFE, 33, 1'b0);
        run_op("mul_79", 4'd9, 32'd7, 32'd9, 5'd0,
               32'd63, 33, 1'b0);
        run_op("mul_0", 4'd9, 32'h1234_5678, 32'd0, 5'd0,
               32'd0, 33, 1'b0);

        // back-pressure with ignored requests
        issue(4'd2, 32'h7FFF_FFFF, 32'd1, 5'd0);
        check("bp_vld0", 64'(bus.out_valid_o), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.in_valid_i = (i % 2 == 0);
            bus.ctrl_i     = 4'd2;
            bus.src1_i     = 32'd5;
            bus.src2_i     = 32'd6;
        end
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        check("bp_res", 64'(bus.result_o), 64'h8000_0000);
        check("bp_vld", 64'(bus.out_valid_o), 64'd1);
        check("bp_rdy", 64'(bus.in_ready_o), 64'd0);
        check("bp_zero", 64'(bus.zero_o), 64'd0);
        consume("bp");

        // reset in the middle of a multiply
        issue(4'd9, 32'd7, 32'd9, 5'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst_res", 64'(bus.result_o), 64'd0);
        check("mrst_zero", 64'(bus.zero_o), 64'd0);
        check("mrst_vld", 64'(bus.out_valid_o), 64'd0);
        check("mrst_rdy", 64'(bus.in_ready_o), 64'd1);
        check("mrst_div0", 64'(bus.div0_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("add_after", 4'd2, 32'd1, 32'd2, 5'd0,
               32'd3, 1, 1'b0);

`ifdef ALU_MC_DIV_EN
        run_op("divu", 4'd10, 32'd100, 32'd7, 5'd0,
               32'd14, 33, 1'b0);
        run_op("remu", 4'd11, 32'd100, 32'd7, 5'd0,
               32'd2, 33, 1'b0);
        run_op("divu0", 4'd10, 32'd5, 32'd0, 5'd0,
               32'hFFFF_FFFF, 33, 1'b1);
        run_op("remu0", 4'd11, 32'd5, 32'd0, 5'd0,
               32'd5, 33, 1'b1);
        run_op("divu_big", 4'd10, 32'hFFFF_FFFF, 32'd16, 5'd0,
               32'h0FFF_FFFF, 33, 1'b0);
        run_op("after_div0", 4'd2, 32'd4, 32'd4, 5'd0,
               32'd8, 1, 1'b0);
`else
        run_op("divu_off", 4'd10, 32'd100, 32'd7, 5'd0,
               32'd0, 1, 1'b0);
        run_op("remu_off", 4'd11, 32'd100, 32'd7, 5'd0,
               32'd0, 1, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
